// File: rtl/result_serializer_if.sv
// Handshake bundle for result_serializer: parallel capture side and single-bit serial side.
interface result_serializer_if #(
  parameter int WIDTH = 17
);
  logic [WIDTH-1:0] cap_data;
  logic             cap_valid;
  logic             cap_ready;
  logic             ser_data;
  logic             ser_valid;
  logic             ser_ready;
  logic             ser_last;

  // master is the environment: it offers words and consumes bits
  modport master (
    output cap_data, cap_valid, ser_ready,
    input  cap_ready, ser_data, ser_valid, ser_last
  );

  modport slave (
    input  cap_data, cap_valid, ser_ready,
    output cap_ready, ser_data, ser_valid, ser_last
  );
endinterface

// File: rtl/result_serializer.sv
// Captures one compressor result word and shifts it out LSB first on a 1-bit valid/ready stream.
// Optional even-parity trailer bit enabled by defining RESULT_SER_PARITY_EN.
module result_serializer #(
  parameter int WIDTH = 17,
  parameter int CNT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  result_serializer_if.slave bus,
  output logic               busy,
  output logic [15:0]        word_count
);

`ifdef RESULT_SER_PARITY_EN
  localparam int WORD_W = WIDTH + 1;
`else
  localparam int WORD_W = WIDTH;
`endif
  localparam int LAST = WORD_W - 1;
  // Only compared on non-final transfers, so the wrapped value for LAST=0 is never used.
  localparam logic [CNT_W-1:0] CNT_PRE_LAST = CNT_W'(LAST - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state;
  logic [WORD_W-1:0] shreg;
  logic [CNT_W-1:0]  cnt;
  logic              ser_valid_q;
  logic              ser_last_q;
  logic [WORD_W-1:0] load_word;
  logic              cap_ready_c;
  logic              xfer;

`ifdef RESULT_SER_PARITY_EN
  assign load_word = {^bus.cap_data, bus.cap_data};
`else
  assign load_word = bus.cap_data;
`endif

  // NOTE: cap_ready looks at ser_ready combinationally so a new word can load on the
  // final-bit transfer, giving back-to-back words without an idle cycle.
  assign cap_ready_c = !rst && ((state == IDLE) ||
                                (state == SHIFT && ser_last_q && bus.ser_ready));
  assign xfer        = ser_valid_q && bus.ser_ready;

  assign bus.cap_ready = cap_ready_c;
  assign bus.ser_valid = ser_valid_q;
  assign bus.ser_last  = ser_last_q;
  assign bus.ser_data  = shreg[0];

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      shreg       <= '0;
      cnt         <= '0;
      ser_valid_q <= 1'b0;
      ser_last_q  <= 1'b0;
      busy        <= 1'b0;
      word_count  <= '0;
    end else begin
      if (xfer && ser_last_q) begin
        word_count <= word_count + 16'd1;
      end

      if (bus.cap_valid && cap_ready_c) begin
        state       <= SHIFT;
        shreg       <= load_word;
        cnt         <= '0;
        ser_valid_q <= 1'b1;
        ser_last_q  <= (LAST == 0);
        busy        <= 1'b1;
      end else if (xfer && ser_last_q) begin
        state       <= IDLE;
        shreg       <= '0;
        cnt         <= '0;
        ser_valid_q <= 1'b0;
        ser_last_q  <= 1'b0;
        busy        <= 1'b0;
      end else if (xfer) begin
        shreg      <= shreg >> 1;
        cnt        <= cnt + 1'b1;
        ser_last_q <= (cnt == CNT_PRE_LAST);
      end
    end
  end

endmodule

// File: tb/tb_result_serializer.sv
// Randomized scoreboard bench for result_serializer: a bit-level queue model checked by an
// independent monitor, plus a WIDTH=1 instance driven through the 16-bit word_count wrap.
module tb_result_serializer;
  localparam int WIDTH = 17;
`ifdef RESULT_SER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int NB = WIDTH + int'(PAR);

  typedef struct packed {
    logic data;
    logic last;
  } bit_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rst1 = 1'b1;
  logic        busy, busy1;
  logic [15:0] word_count, word_count1;

  result_serializer_if #(.WIDTH(WIDTH)) bus ();
  result_serializer_if #(.WIDTH(1))     bus1 ();

  result_serializer #(.WIDTH(WIDTH), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy), .word_count(word_count)
  );

  result_serializer #(.WIDTH(1), .CNT_W(1)) dut1 (
    .clk(clk), .rst(rst1), .bus(bus1), .busy(busy1), .word_count(word_count1)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a word becomes its bits in LSB-first order, plus the parity trailer.
  bit_t sb[$];
  int   exp_words = 0;

  task automatic push_word(input logic [WIDTH-1:0] d);
    bit_t b;
    for (int i = 0; i < WIDTH; i++) begin
      b.data = d[i];
      b.last = !PAR && (i == WIDTH - 1);
      sb.push_back(b);
    end
    if (PAR) begin
      b.data = ($countones(d) % 2) == 1;
      b.last = 1'b1;
      sb.push_back(b);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Monitor: compares every transfer and stall cycle against the model queue.
  int   xfer_cnt = 0;
  int   last_cyc = 0;
  logic prev_stall = 1'b0;
  logic prev_data = 1'b0;
  logic prev_last = 1'b0;

  always @(negedge clk) begin
    bit_t e;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      check("ser_valid", bus.ser_valid, sb.size() != 0);
      check("busy", busy, sb.size() != 0);
      check("cap_ready", bus.cap_ready, (sb.size() == 0) || (sb.size() == 1 && bus.ser_ready));
      if (prev_stall) begin
        check("hold_valid", bus.ser_valid, 1);
        check("hold_data", bus.ser_data, prev_data);
        check("hold_last", bus.ser_last, prev_last);
      end
      if (bus.ser_valid && bus.ser_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_bit", 1, 0);
        end else begin
          e = sb.pop_front();
          check("ser_data", bus.ser_data, e.data);
          check("ser_last", bus.ser_last, e.last);
          if (e.last) begin
            exp_words++;
            last_cyc = cyc;
          end
        end
        xfer_cnt++;
      end
      prev_stall = bus.ser_valid && !bus.ser_ready;
      prev_data  = bus.ser_data;
      prev_last  = bus.ser_last;
    end
  end

  // ser_ready generator: 0 = always ready, 1 = 1,0,0,1 pattern, 2 = random stalls.
  int rdy_mode = 0;
  int pat_idx = 0;
  initial begin
    bus.ser_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.ser_ready = 1'b1;
        1: begin
          bus.ser_ready = (pat_idx % 4 == 0) || (pat_idx % 4 == 3);
          pat_idx++;
        end
        default: bus.ser_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  int acc_cyc = 0;

  // Offers a word and leaves cap_valid high; returns at posedge+1 of the capturing edge.
  task automatic send_word(input logic [WIDTH-1:0] d);
    bit ok = 1'b0;
    bus.cap_data  = d;
    bus.cap_valid = 1'b1;
    for (int g = 0; g < 2000 && !ok; g++) begin
      @(negedge clk);
      if (bus.cap_ready) begin
        ok = 1'b1;
        acc_cyc = cyc;
      end
      @(posedge clk);
      #1;
    end
    if (ok) begin
      push_word(d);
      check("first_bit_valid", bus.ser_valid, 1);
      check("first_bit_data", bus.ser_data, d[0]);
    end else begin
      check("accept_timeout", 0, 1);
    end
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int g = 0; g < 3000 && !ok; g++) begin
      @(negedge clk);
      if (sb.size() == 0 && !bus.ser_valid) ok = 1'b1;
    end
    if (!ok) check("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  // WIDTH=1 instance: one word per cycle until word_count wraps.
  int          wrap_words = 0;
  bit          wrap_done = 1'b0;
  bit          chk1_pending = 1'b0;
  logic [15:0] exp1 = '0;

  initial begin
    bus1.cap_data  = 1'b1;
    bus1.cap_valid = 1'b0;
    bus1.ser_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst1 = 1'b0;
    bus1.cap_valid = 1'b1;
    for (int g = 0; g < 140000 && wrap_words < 65536; g++) @(posedge clk);
    #1;
    bus1.cap_valid = 1'b0;
    repeat (4) @(posedge clk);
    wrap_done = 1'b1;
  end

  always @(negedge clk) begin
    if (!rst1) begin
      if (chk1_pending) begin
        check("wrap_word_count", word_count1, exp1);
        chk1_pending = 1'b0;
      end
      if (bus1.ser_valid && bus1.ser_ready && bus1.ser_last) begin
        wrap_words++;
        if (wrap_words == 1 || wrap_words == 65535 || wrap_words == 65536) begin
          chk1_pending = 1'b1;
          exp1 = 16'(wrap_words);
        end
      end
    end
  end

  initial begin
    logic [WIDTH-1:0] d;
    int a1;
    bus.cap_valid = 1'b0;
    bus.cap_data  = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ser_valid", bus.ser_valid, 0);
    check("rst_ser_data", bus.ser_data, 0);
    check("rst_ser_last", bus.ser_last, 0);
    check("rst_busy", busy, 0);
    check("rst_word_count", word_count, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("cap_ready_after_reset", bus.cap_ready, 1);

    // Basic word, always ready
    rdy_mode = 0;
    send_word(17'h12345);
    bus.cap_valid = 1'b0;
    drain();
    check("basic_span", last_cyc - acc_cyc, NB);
    check("basic_word_count", word_count, 1);

    // Backpressure pattern 1,0,0,1
    rdy_mode = 1;
    pat_idx  = 0;
    send_word(17'h12345);
    bus.cap_valid = 1'b0;
    drain();
    check("bp_word_count", word_count, 2);

    // Back-to-back words with cap_valid held
    rdy_mode = 0;
    send_word(17'h1FFFF);
    a1 = acc_cyc;
    send_word(17'h00001);
    bus.cap_valid = 1'b0;
    drain();
    check("b2b_no_bubble_span", last_cyc - a1, 2 * NB);
    check("b2b_word_count", word_count, 4);

    // Parity-relevant word (even number of ones)
    send_word(17'h00003);
    bus.cap_valid = 1'b0;
    drain();

    // Random words, random stalls, random gaps
    rdy_mode = 2;
    for (int k = 0; k < 24; k++) begin
      d = WIDTH'($urandom);
      send_word(d);
      if ($urandom_range(0, 2) == 0) begin
        bus.cap_valid = 1'b0;
        repeat ($urandom_range(0, 20)) @(posedge clk);
        #1;
      end
    end
    bus.cap_valid = 1'b0;
    drain();
    check("random_word_count", word_count, 16'(exp_words));

    // Reset in the middle of a word
    rdy_mode = 0;
    xfer_cnt = 0;
    send_word(17'h12345);
    bus.cap_valid = 1'b0;
    for (int g = 0; g < 200 && xfer_cnt < 5; g++) @(posedge clk);
    #2;
    rst = 1'b1;
    sb.delete();
    exp_words = 0;
    #1;
    check("midrst_ser_valid", bus.ser_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_word_count", word_count, 0);
    check("midrst_ser_last", bus.ser_last, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send_word(17'h0ABCD);
    bus.cap_valid = 1'b0;
    drain();
    check("post_rst_word_count", word_count, 1);

    // Wait for the wrap instance
    for (int g = 0; g < 150000 && !wrap_done; g++) @(posedge clk);
    check("wrap_finished", wrap_done, 1);
    check("wrap_words_seen", wrap_words >= 65536, 1);
    #1;
    check("wrap_idle_valid", bus1.ser_valid, 0);
    check("wrap_idle_busy", busy1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
